// File: rtl/step_controller.sv
// rtl/step_controller.sv - step/free-run gate for the bilinear downscaling datapath
// Consumer of the 0xF9 step-control bits: issues dp_en steps and reports status.
module step_controller #(
  parameter int CNT_W   = 16,
  parameter int TO_W    = 12,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step_pulse,
  input  logic             dp_step_ack,
  input  logic             frame_done,
  output logic             dp_en,
  output logic             clr_step_req,
  output logic [CNT_W-1:0] step_count,
  output logic [7:0]       status
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_ARMED, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic            TO_EN   = (TIMEOUT != 0);

  state_t          state;
  logic            pulse_q;
  logic            step_edge;
  logic [TO_W-1:0] wait_cnt;
  logic            timeout_f;
  logic            overrun_f;

  assign step_edge = step_pulse & ~pulse_q;
  assign dp_en     = (state == S_RUN) || (state == S_ISSUE);

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state        <= S_IDLE;
      pulse_q      <= 1'b0;
      step_count   <= '0;
      wait_cnt     <= '0;
      timeout_f    <= 1'b0;
      overrun_f    <= 1'b0;
      clr_step_req <= 1'b0;
      status       <= 8'h00;
    end else begin
      pulse_q      <= step_pulse;
      clr_step_req <= 1'b0;
      status       <= {2'b00, overrun_f, timeout_f,
                       state == S_DONE,
                       (state == S_ISSUE) || (state == S_WAIT),
                       state == S_ARMED,
                       !((state == S_IDLE) || (state == S_DONE))};

      // A step request while one is still outstanding is not queued.
      if (step_edge && ((state == S_ISSUE) || (state == S_WAIT)))
        overrun_f <= 1'b1;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= step_mode ? S_ARMED : S_RUN;
            step_count <= '0;
            timeout_f  <= 1'b0;
            overrun_f  <= 1'b0;
          end
        end
        S_RUN: begin
          if (frame_done)     state <= S_DONE;
          else if (step_mode) state <= S_ARMED;
        end
        S_ARMED: begin
          if (frame_done)      state <= S_DONE;
          else if (!step_mode) state <= S_RUN;
          else if (step_edge)  state <= S_ISSUE;
        end
        S_ISSUE: begin
          state    <= S_WAIT;
          wait_cnt <= '0;
          if (step_count != {CNT_W{1'b1}})
            step_count <= step_count + 1'b1;
        end
        S_WAIT: begin
          if (frame_done) begin
            state <= S_DONE;
          end else if (dp_step_ack) begin
            state        <= S_ARMED;
            clr_step_req <= 1'b1;
          end else if (TO_EN && (wait_cnt == TO_LAST)) begin
            state        <= S_ARMED;
            timeout_f    <= 1'b1;
            clr_step_req <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
